sap1_datapath: RTL



---
 rtl/sap1_datapath.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/sap1_datapath.sv
// SAP-1 datapath: PC, MAR, RAM, IR, A, B, adder and shared bus.
// Optional carry/zero flags are built when SAP1_FLAGS_EN is defined.
module sap1_datapath #(
  parameter int MEM_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] control_word,
  output logic [3:0]  opcode,
  input  logic        prog_valid,
  output logic        prog_ready,
  input  logic [3:0]  prog_addr,
  input  logic [7:0]  prog_data,
  input  logic        prog_start,
  output logic        run,
  output logic        halted,
  output logic [7:0]  a_out,
  output logic [7:0]  bus_out,
  output logic        bus_conflict
`ifdef SAP1_FLAGS_EN
  ,
  output logic        carry,
  output logic        zero
`endif
);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_RUN,
    ST_HALT
  } state_e;

  state_e state_q, state_d;

  logic [3:0] pc_q, pc_d;
  logic [3:0] mar_q, mar_d;
  logic [7:0] ir_q, ir_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic       conf_q, conf_d;
  logic [7:0] ram_q [MEM_DEPTH];

  logic cw_hlt, cw_pc_inc, cw_pc_en;
  logic cw_mar_ld, cw_mem_en, cw_ir_ld;
  logic cw_ir_en, cw_a_ld, cw_a_en;
  logic cw_b_ld, cw_sub, cw_add_en;

  logic       in_run;
  logic       start_run;
  logic       ram_we;
  logic [7:0] bus;
  logic       src_adder;
  logic [2:0] en_cnt;
  logic [7:0] b_opnd;
  logic [7:0] adder_res;
`ifdef SAP1_FLAGS_EN
  logic       adder_co;
  logic       carry_q, carry_d;
  logic       zero_q, zero_d;
`endif

  always_comb begin
    cw_hlt    = control_word[11];
    cw_pc_inc = control_word[10];
    cw_pc_en  = control_word[9];
    cw_mar_ld = control_word[8];
    cw_mem_en = control_word[7];
    cw_ir_ld  = control_word[6];
    cw_ir_en  = control_word[5];
    cw_a_ld   = control_word[4];
    cw_a_en   = control_word[3];
    cw_b_ld   = control_word[2];
    cw_sub    = control_word[1];
    cw_add_en = control_word[0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_LOAD;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_LOAD, ST_HALT: begin
        if (prog_start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (cw_hlt) state_d = ST_HALT;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_comb begin
    in_run     = (state_q == ST_RUN);
    run        = in_run;
    halted     = (state_q == ST_HALT);
    prog_ready = !in_run;
  end

  always_comb begin
    start_run = !in_run && prog_start;
    ram_we    = prog_valid && prog_ready;
  end

  // Subtract is A + ~B + 1 so carry-out means "no borrow".
  always_comb begin
    b_opnd = cw_sub ? ~b_q : b_q;
`ifdef SAP1_FLAGS_EN
    {adder_co, adder_res} = {1'b0, a_q}
                          + {1'b0, b_opnd}
                          + {8'b0, cw_sub};
`else
    adder_res = a_q + b_opnd + {7'b0, cw_sub};
`endif
  end

  always_comb begin
    bus       = 8'h00;
    src_adder = 1'b0;
    if (cw_pc_en)       bus = {4'b0, pc_q};
    else if (cw_mem_en) bus = ram_q[mar_q];
    else if (cw_ir_en)  bus = {4'b0, ir_q[3:0]};
    else if (cw_a_en)   bus = a_q;
    else if (cw_add_en) begin
      bus       = adder_res;
      src_adder = 1'b1;
    end
  end

  always_comb begin
    en_cnt = {2'b0, cw_pc_en}
           + {2'b0, cw_mem_en}
           + {2'b0, cw_ir_en}
           + {2'b0, cw_a_en}
           + {2'b0, cw_add_en};
  end

  always_comb begin
    pc_d   = pc_q;
    mar_d  = mar_q;
    ir_d   = ir_q;
    a_d    = a_q;
    b_d    = b_q;
    conf_d = conf_q;
    if (start_run) begin
      pc_d  = 4'h0;
      mar_d = 4'h0;
      ir_d  = 8'h00;
    end else if (in_run) begin
      if (cw_pc_inc) pc_d = pc_q + 4'd1;
      if (cw_mar_ld) mar_d = bus[3:0];
      if (cw_ir_ld)  ir_d = bus;
      if (cw_a_ld)   a_d = bus;
      if (cw_b_ld)   b_d = bus;
      if (en_cnt > 3'd1) conf_d = 1'b1;
    end
  end

`ifdef SAP1_FLAGS_EN
  always_comb begin
    carry_d = carry_q;
    zero_d  = zero_q;
    if (in_run && cw_a_ld && src_adder) begin
      carry_d = adder_co;
      zero_d  = (adder_res == 8'h00);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      carry_q <= carry_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    carry = carry_q;
    zero  = zero_q;
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q   <= 4'h0;
      mar_q  <= 4'h0;
      ir_q   <= 8'h00;
      a_q    <= 8'h00;
      b_q    <= 8'h00;
      conf_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      mar_q  <= mar_d;
      ir_q   <= ir_d;
      a_q    <= a_d;
      b_q    <= b_d;
      conf_q <= conf_d;
    end
  end

  // Program RAM keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (ram_we) ram_q[prog_addr] <= prog_data;
  end

  always_comb begin
    opcode       = ir_q[7:4];
    a_out        = a_q;
    bus_out      = bus;
    bus_conflict = conf_q;
  end

endmodule
